// File: rtl/req_scheduler_pkg.sv
// Shared constants and types for the request scheduler and the control FSM
// that consumes its req bus.
package req_scheduler_pkg;

  localparam int F_N_DEF = 8;

  localparam logic [3:0] RS_UP    = 4'd1;
  localparam logic [3:0] RS_DOWN  = 4'd2;
  localparam logic [3:0] DS_OPEN  = 4'd1;
  localparam logic [3:0] DS_CLOSE = 4'd2;

  // Bit positions inside req; control decodes with the same indices.
  localparam int REQ_UP   = 2;
  localparam int REQ_DOWN = 1;
  localparam int REQ_OPEN = 0;

  typedef struct packed {
    logic go_up;
    logic go_down;
    logic open_door;
  } req_t;

endpackage

// File: rtl/req_scheduler_pend_reg.sv
// Set/clear latch vector: q <= (q | set) & ~clr, clear dominant, sync reset.
module pend_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_set,
  input  logic [W-1:0] i_clr,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) r_q <= '0;
    else     r_q <= (r_q | i_set) & ~i_clr;
  end

  assign o_q = r_q;

endmodule

// File: rtl/req_scheduler.sv
// Latches cab/hall calls per floor, clears them when served at the current
// floor, and reports {go_up, go_down, open_door} to the control FSM.
import req_scheduler_pkg::*;

module req_scheduler #(
  parameter int F_N = F_N_DEF
) (
  input  logic           clk10hz,
  input  logic           rst,
  input  logic [F_N-1:0] cab_btn,
  input  logic [F_N-1:0] hall_up,
  input  logic [F_N-1:0] hall_down,
  input  logic [7:0]     curr_floor,
  input  logic [3:0]     running_state,
  input  logic [3:0]     door_state,
  output logic [2:0]     req,
  output logic [F_N-1:0] cab_pend,
  output logic [F_N-1:0] up_pend,
  output logic [F_N-1:0] down_pend
);

  // No up-call exists at the top floor, no down-call at floor 0.
  localparam logic [F_N-1:0] UP_MASK = {1'b0, {(F_N-1){1'b1}}};
  localparam logic [F_N-1:0] DN_MASK = {{(F_N-1){1'b1}}, 1'b0};
  localparam logic [F_N-1:0] ONE     = {{(F_N-1){1'b0}}, 1'b1};

  logic [F_N-1:0] w_cab, w_up, w_dn;
  logic [F_N-1:0] w_any, w_sel;
  logic [F_N-1:0] w_clr_cab, w_clr_up, w_clr_dn;
  logic           w_valid, w_dir_up, w_door_open;
  logic           w_above, w_below, w_opp_ok, w_here;
  logic           w_cab_here, w_up_here, w_dn_here;
  req_t           r_req;

  assign w_valid     = int'(curr_floor) < F_N;
  assign w_dir_up    = (running_state == RS_UP);
  assign w_door_open = (door_state == DS_OPEN);
  assign w_any       = w_cab | w_up | w_dn;
  assign w_sel       = w_valid ? (ONE << curr_floor) : '0;

  always_comb begin
    w_above = 1'b0;
    w_below = 1'b0;
    for (int i = 0; i < F_N; i++) begin
      if (i > int'(curr_floor)) w_above = w_above | w_any[i];
      if (i < int'(curr_floor)) w_below = w_below | w_any[i];
    end
  end

  assign w_cab_here = |(w_cab & w_sel);
  assign w_up_here  = |(w_up  & w_sel);
  assign w_dn_here  = |(w_dn  & w_sel);

  // Opposite-direction call at this floor is served only when the car has
  // nothing further to do in its current direction.
  assign w_opp_ok = w_dir_up ? ~w_above : ~w_below;
  assign w_here   = w_cab_here
                  | (w_dir_up ? w_up_here : w_dn_here)
                  | (w_opp_ok & (w_dir_up ? w_dn_here : w_up_here));

  assign w_clr_cab = w_door_open ? w_sel : '0;
  assign w_clr_up  = (w_door_open && (w_dir_up  || w_opp_ok)) ? w_sel : '0;
  assign w_clr_dn  = (w_door_open && (!w_dir_up || w_opp_ok)) ? w_sel : '0;

  pend_reg #(.W(F_N)) u_cab (
    .clk (clk10hz), .rst (rst),
    .i_set (cab_btn), .i_clr (w_clr_cab), .o_q (w_cab)
  );

  pend_reg #(.W(F_N)) u_up (
    .clk (clk10hz), .rst (rst),
    .i_set (hall_up & UP_MASK), .i_clr (w_clr_up), .o_q (w_up)
  );

  pend_reg #(.W(F_N)) u_dn (
    .clk (clk10hz), .rst (rst),
    .i_set (hall_down & DN_MASK), .i_clr (w_clr_dn), .o_q (w_dn)
  );

  always_ff @(posedge clk10hz) begin
    if (rst || !w_valid) begin
      r_req <= '0;
    end else begin
      r_req.go_up     <= w_above;
      r_req.go_down   <= w_below;
      r_req.open_door <= w_here & ~w_door_open;
    end
  end

  assign req       = r_req;
  assign cab_pend  = w_cab;
  assign up_pend   = w_up;
  assign down_pend = w_dn;

endmodule
